block_output: RTL and testbench

//  Output stage of one router port; sits directly downstream of the NUM_IN block_input instances.

---
 rtl/block_output_pkg.sv | 36 +++
 rtl/block_output_if.sv | 29 ++
 rtl/noc_fifo.sv | 68 ++++++
 rtl/block_output.sv | 143 ++++++++++++++
 tb/tb_block_output.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/block_output_pkg.sv
// Shared definitions for the router output stage: default sizes, port
// index constants, FSM state type and the fixed-priority order helper.
package block_output_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int NUM_IN_DEF     = 5;
  localparam int FIFO_DEPTH_DEF = 4;

  // Input port indices; the same numbering is used for route direction.
  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_S = 2;
  localparam int PORT_W = 3;
  localparam int PORT_L = 4;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Port examined at a given rank of the fixed-priority search:
  // Local first, then N, E, S, W.
  function automatic int prio_port(input int rank);
    int port;
    case (rank)
      0:       port = PORT_L;
      1:       port = PORT_N;
      2:       port = PORT_E;
      3:       port = PORT_S;
      4:       port = PORT_W;
      default: port = PORT_L;
    endcase
    return port;
  endfunction

endpackage

// File: rtl/block_output_if.sv
// Bundle of the output-stage signals: upstream request/grant side and
// downstream val/ret side. The output stage uses the slave modport.
interface block_output_if
  import block_output_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_IN     = NUM_IN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
);

  logic [NUM_IN-1:0]          req;
  logic [NUM_IN*DATA_W-1:0]   data_in;
  logic [NUM_IN-1:0]          grant;
  logic                       val_out;
  logic [DATA_W-1:0]          data_out;
  logic                       ret_in;
  logic [$clog2(FIFO_DEPTH):0] count;

  modport master (
    output req, data_in, ret_in,
    input  grant, val_out, data_out, count
  );

  modport slave (
    input  req, data_in, ret_in,
    output grant, val_out, data_out, count
  );

endinterface

// File: rtl/noc_fifo.sv
// Small synchronous FIFO used for output (and input) flit buffering.
// Depth must be a power of two so the pointers wrap naturally.
// Push while full and pop while empty are ignored.
module noc_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_W-1:0]           din,
  output logic [DATA_W-1:0]           dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign full      = (count_r == CW'(FIFO_DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Flit storage; cleared on reset so the head reads zero when empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Read/write pointers and occupancy; simultaneous push and pop keep count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/block_output.sv
// Output stage of one router port. Picks one requesting input, locks the
// port to it for the whole packet, buffers accepted flits in noc_fifo and
// forwards them over val_out/ret_in.
// Build option: RR_ARB_EN selects round-robin arbitration; without it the
// fixed order Local > N > E > S > W is used and no rotation pointer exists.
module block_output
  import block_output_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_IN     = NUM_IN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic           clk,
  input logic           rst,
  block_output_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_IN);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [NUM_IN-1:0] ONE_HOT0 = {{(NUM_IN-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic [IDX_W-1:0]  owner_r;
  logic [NUM_IN-1:0] grant_r;
`ifdef RR_ARB_EN
  logic [IDX_W-1:0]  rr_ptr_r;
`endif

  logic [IDX_W-1:0]  win_s;
  logic [IDX_W-1:0]  cand_s;
  logic              found_s;
  logic              push_s;
  logic              pop_s;
  logic [DATA_W-1:0] push_data_s;
  logic [DATA_W-1:0] head_s;
  logic              full_s;
  logic              empty_s;
  logic [CNT_W-1:0]  count_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              full_next_s;

  // Winner search: first requesting input in arbitration order.
  always_comb begin
    win_s   = {IDX_W{1'b0}};
    cand_s  = {IDX_W{1'b0}};
    found_s = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
`ifdef RR_ARB_EN
      cand_s = IDX_W'((int'(rr_ptr_r) + k) % NUM_IN);
`else
      cand_s = IDX_W'(prio_port(k));
`endif
      if (!found_s && bus.req[cand_s]) begin
        win_s   = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // A flit is taken only while granted; full gating is kept as a safety net.
  assign push_s      = (|(grant_r & bus.req)) & ~full_s;
  assign push_data_s = bus.data_in[owner_r*DATA_W +: DATA_W];
  assign pop_s       = ~empty_s & bus.ret_in;

  // Occupancy after this edge, used to decide next cycle's grant.
  always_comb begin
    cnt_next_s = count_s;
    if (push_s && !pop_s) begin
      cnt_next_s = count_s + CNT_W'(1);
    end else if (pop_s && !push_s) begin
      cnt_next_s = count_s - CNT_W'(1);
    end else begin
      cnt_next_s = count_s;
    end
  end

  assign full_next_s = (cnt_next_s == CNT_W'(FIFO_DEPTH));

  // Arbitration/lock FSM. grant is registered and equals
  // onehot(owner) & ~full for the cycle it is presented, so a pop in the
  // same cycle as full never re-opens the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      owner_r  <= {IDX_W{1'b0}};
      grant_r  <= {NUM_IN{1'b0}};
`ifdef RR_ARB_EN
      rr_ptr_r <= {IDX_W{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|bus.req) begin
            owner_r <= win_s;
            state_r <= ST_LOCKED;
            grant_r <= full_next_s ? {NUM_IN{1'b0}} : (ONE_HOT0 << win_s);
          end else begin
            grant_r <= {NUM_IN{1'b0}};
          end
        end
        ST_LOCKED: begin
          if (!bus.req[owner_r]) begin
            state_r  <= ST_IDLE;
            grant_r  <= {NUM_IN{1'b0}};
`ifdef RR_ARB_EN
            rr_ptr_r <= (owner_r == IDX_W'(NUM_IN - 1)) ? {IDX_W{1'b0}}
                                                        : owner_r + IDX_W'(1);
`endif
          end else begin
            grant_r <= full_next_s ? {NUM_IN{1'b0}} : (ONE_HOT0 << owner_r);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= {NUM_IN{1'b0}};
        end
      endcase
    end
  end

  noc_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_data_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  assign bus.grant    = grant_r;
  assign bus.val_out  = ~empty_s;
  assign bus.data_out = head_s;
  assign bus.count    = count_s;

endmodule

// File: tb/tb_block_output.sv
// Bench for block_output: table-driven single-packet check, hand-written
// corner sequences and a randomized phase against a queue-based model.
module tb_block_output;
  import block_output_pkg::*;

  localparam int DW    = 8;
  localparam int NI    = 5;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  block_output_if #(.DATA_W(DW), .NUM_IN(NI), .FIFO_DEPTH(DEPTH)) bus();

  block_output #(.DATA_W(DW), .NUM_IN(NI), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_locked;
  int          m_owner;
  int          m_rr;
  byte unsigned mq[$];
  byte unsigned deliv[$];
  int          owner_log[$];

  // Per-input packet sources
  byte unsigned src_q[NI][$];
  byte unsigned pend_q[NI][$];
  int          len_q[NI][$];
  bit          hold_low[NI];
  byte unsigned last_pkt[$];
  int          gen_cnt;

  bit          last_acc;
  int          last_owner;

  logic [NI-1:0]    req_v;
  logic [NI*DW-1:0] data_v;
  logic             ret_v;

  typedef struct packed {
    logic [NI-1:0] req;
    logic [7:0]    d4;
    logic          ret;
    logic [NI-1:0] eg;
    logic          ev;
    logic [7:0]    ed;
    logic [2:0]    ec;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [NI-1:0] r);
`ifdef RR_ARB_EN
    for (int k = 0; k < NI; k++) begin
      if (r[(m_rr + k) % NI]) return (m_rr + k) % NI;
    end
`else
    int order [NI];
    order = '{4, 0, 1, 2, 3};
    for (int k = 0; k < NI; k++) begin
      if (r[order[k]]) return order[k];
    end
`endif
    return 0;
  endfunction

  function automatic logic [NI-1:0] exp_grant();
    logic [NI-1:0] g;
    g = '0;
    if (m_locked && mq.size() < DEPTH) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic bit all_done();
    bit d;
    d = (mq.size() == 0) && !m_locked;
    for (int i = 0; i < NI; i++) begin
      if (src_q[i].size() != 0 || len_q[i].size() != 0 || hold_low[i]) d = 1'b0;
    end
    return d;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_locked = 1'b0;
    m_owner  = 0;
    m_rr     = 0;
    for (int i = 0; i < NI; i++) begin
      src_q[i].delete();
      pend_q[i].delete();
      len_q[i].delete();
      hold_low[i] = 1'b0;
    end
  endtask

  // Apply req_v/data_v/ret_v for one clock edge, advance the model, compare.
  task automatic edge_step();
    logic [NI-1:0] g;
    bit acc;
    bit pp;
    byte unsigned acc_d;
    bus.req     = req_v;
    bus.data_in = data_v;
    bus.ret_in  = ret_v;
    g     = exp_grant();
    acc   = m_locked && g[m_owner] && req_v[m_owner];
    acc_d = data_v[m_owner*DW +: DW];
    pp    = (mq.size() > 0) && ret_v;
    @(posedge clk);
    #1;
    if (pp) deliv.push_back(mq.pop_front());
    if (acc) mq.push_back(acc_d);
    last_acc   = acc;
    last_owner = m_owner;
    if (!m_locked) begin
      if (req_v != '0) begin
        m_owner  = pick(req_v);
        m_locked = 1'b1;
        owner_log.push_back(m_owner);
      end
    end else if (!req_v[m_owner]) begin
      m_locked = 1'b0;
      m_rr     = (m_owner + 1) % NI;
    end
    check("grant", 32'(bus.grant), 32'(exp_grant()));
    check("val_out", 32'(bus.val_out), 32'(mq.size() > 0));
    if (mq.size() > 0) check("data_out", 32'(bus.data_out), 32'(mq[0]));
    check("count", 32'(bus.count), 32'(mq.size()));
  endtask

  // Drive requests from the per-input packet queues for one edge.
  task automatic src_step();
    for (int i = 0; i < NI; i++) begin
      if (src_q[i].size() == 0) begin
        if (hold_low[i]) begin
          hold_low[i] = 1'b0;
        end else if (len_q[i].size() > 0) begin
          int n;
          n = len_q[i].pop_front();
          repeat (n) src_q[i].push_back(pend_q[i].pop_front());
        end
      end
      req_v[i] = (src_q[i].size() > 0);
      data_v[i*DW +: DW] = req_v[i] ? src_q[i][0] : 8'h00;
    end
    edge_step();
    if (last_acc) begin
      void'(src_q[last_owner].pop_front());
      if (src_q[last_owner].size() == 0) hold_low[last_owner] = 1'b1;
    end
  endtask

  task automatic add_pkt(input int i, input int len);
    last_pkt.delete();
    for (int k = 0; k < len; k++) begin
      byte unsigned b;
      b = {3'(i), 5'(gen_cnt)};
      gen_cnt++;
      pend_q[i].push_back(b);
      last_pkt.push_back(b);
    end
    len_q[i].push_back(len);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    ret_v = 1'b1;
    while (!all_done() && k < budget) begin
      src_step();
      k++;
    end
    check("drain_done", 32'(all_done()), 32'd1);
  endtask

  task automatic check_deliv(input string name);
    check({name, "_len"}, 32'(deliv.size()), 32'(last_pkt.size()));
    for (int k = 0; k < last_pkt.size() && k < deliv.size(); k++) begin
      check({name, "_flit"}, 32'(deliv[k]), 32'(last_pkt[k]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    int k;
    int tot;

    rst = 1'b0;
    req_v = '0; data_v = '0; ret_v = 1'b0;
    bus.req = '0; bus.data_in = '0; bus.ret_in = 1'b0;
    gen_cnt = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_val", 32'(bus.val_out), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ret_v = 1'b1;
    edge_step();

    // Test 1: single packet on Local, table-driven
    tbl[0] = '{5'b10000, 8'hAE, 1'b1, 5'b10000, 1'b0, 8'h00, 3'd0};
    tbl[1] = '{5'b10000, 8'hAE, 1'b1, 5'b10000, 1'b1, 8'hAE, 3'd1};
    tbl[2] = '{5'b10000, 8'hFA, 1'b1, 5'b10000, 1'b1, 8'hFA, 3'd1};
    tbl[3] = '{5'b10000, 8'hF8, 1'b1, 5'b10000, 1'b1, 8'hF8, 3'd1};
    tbl[4] = '{5'b00000, 8'h00, 1'b1, 5'b00000, 1'b0, 8'h00, 3'd0};
    deliv.delete();
    for (int v = 0; v < 5; v++) begin
      req_v  = tbl[v].req;
      data_v = {tbl[v].d4, 32'h0000_0000};
      ret_v  = tbl[v].ret;
      edge_step();
      check("t1_grant", 32'(bus.grant), 32'(tbl[v].eg));
      check("t1_val", 32'(bus.val_out), 32'(tbl[v].ev));
      check("t1_count", 32'(bus.count), 32'(tbl[v].ec));
      if (tbl[v].ev) check("t1_data", 32'(bus.data_out), 32'(tbl[v].ed));
    end
    last_pkt = '{8'hAE, 8'hFA, 8'hF8};
    check_deliv("t1_seq");
    req_v = '0; data_v = '0;
    edge_step();

    // Test 2: backpressure, 6 flits into a 4-deep FIFO
    deliv.delete();
    ret_v = 1'b0;
    add_pkt(0, 6);
    repeat (8) src_step();
    check("t2_count_full", 32'(bus.count), 32'd4);
    check("t2_grant_full", 32'(bus.grant), 32'd0);
    drain(60);
    check_deliv("t2_seq");

    // Test 3/4: two inputs contending
    owner_log.delete();
    ret_v = 1'b1;
`ifdef RR_ARB_EN
    repeat (3) begin
      add_pkt(0, 2);
      add_pkt(1, 2);
    end
    drain(120);
    check("t3_npkts", 32'(owner_log.size()), 32'd6);
    for (int j = 1; j < owner_log.size(); j++) begin
      check("t3_alternate", 32'(owner_log[j] != owner_log[j-1]), 32'd1);
    end
`else
    add_pkt(1, 2);
    add_pkt(4, 2);
    drain(60);
    check("t4_npkts", 32'(owner_log.size()), 32'd2);
    if (owner_log.size() == 2) begin
      check("t4_first", 32'(owner_log[0]), 32'd4);
      check("t4_second", 32'(owner_log[1]), 32'd1);
    end
`endif

    // Test 5: simultaneous push and pop with two flits buffered
    deliv.delete();
    ret_v = 1'b0;
    add_pkt(2, 8);
    k = 0;
    while (mq.size() < 2 && k < 20) begin
      src_step();
      k++;
    end
    ret_v = 1'b1;
    repeat (4) begin
      src_step();
      check("t5_count", 32'(bus.count), 32'd2);
    end
    drain(60);
    check_deliv("t5_seq");

    // Test 6: asynchronous reset mid-packet
    ret_v = 1'b0;
    add_pkt(3, 4);
    k = 0;
    while (mq.size() < 2 && k < 20) begin
      src_step();
      k++;
    end
    #2;
    rst = 1'b0;
    #1;
    check("t6_val", 32'(bus.val_out), 32'd0);
    check("t6_grant", 32'(bus.grant), 32'd0);
    check("t6_count", 32'(bus.count), 32'd0);
    model_reset();
    req_v = '0; data_v = '0;
    bus.req = '0; bus.data_in = '0;
    @(negedge clk);
    rst = 1'b1;
    deliv.delete();
    owner_log.delete();
    add_pkt(1, 3);
    drain(60);
    check_deliv("t6_after");
    check("t6_owner", 32'(owner_log.size() > 0 ? owner_log[0] : -1), 32'd1);

    // Randomized traffic
    deliv.delete();
    tot = 0;
    repeat (400) begin
      if ($urandom_range(0, 4) == 0) begin
        int i;
        int len;
        i = int'($urandom_range(0, NI - 1));
        len = int'($urandom_range(1, 5));
        if (len_q[i].size() < 2) begin
          add_pkt(i, len);
          tot += len;
        end
      end
      ret_v = ($urandom_range(0, 3) != 0);
      src_step();
    end
    drain(400);
    check("rand_total", 32'(deliv.size()), 32'(tot));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
